// File: rtl/sdrc_wb_pkg.sv
// Shared definitions for the Wishbone master that feeds the SDRAM controller.
// Contents:
//   CTI_CLASSIC / CTI_INCR / CTI_EOB  Wishbone cycle type identifiers
//   wbm_state_t                       master FSM state encoding
package sdrc_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, BUS, DRAIN} wbm_state_t;

endpackage

// File: rtl/wb_sdrc_master_if.sv
// Bundle of the command, write-data, read-response and Wishbone signals of wb_sdrc_master.
// Modports:
//   master  the wb_sdrc_master side (drives cmd_ready, wd_ready, rd_*, done, err, wb_* requests)
//   slave   the environment side (drives cmd_*, wd_valid/wd_data, wb_ack/wb_dato)
interface wb_sdrc_master_if #(
  parameter int unsigned APP_AW = 26,
  parameter int unsigned DW     = 32,
  parameter int unsigned LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [APP_AW-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [DW/8-1:0]   cmd_sel;
  logic              wd_valid;
  logic              wd_ready;
  logic [DW-1:0]     wd_data;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              rd_last;
  logic              done;
  logic              err;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [DW/8-1:0]   wb_sel;
  logic [APP_AW-1:0] wb_addr;
  logic [DW-1:0]     wb_dati;
  logic [2:0]        wb_cti;
  logic              wb_ack;
  logic [DW-1:0]     wb_dato;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wd_valid, wd_data, wb_ack, wb_dato,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done, err,
           wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dati, wb_cti
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, cmd_sel, wd_valid, wd_data, wb_ack, wb_dato,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last, done, err,
           wb_cyc, wb_stb, wb_we, wb_sel, wb_addr, wb_dati, wb_cti
  );

endinterface

// File: rtl/wb_sdrc_master.sv
// Wishbone B3 master in front of the SDRAM controller's slave port. Converts a command stream
// (addr, len, we, sel) plus a write-data stream into classic / incrementing-burst cycles and
// returns read beats as a response stream. A per-beat ack timeout aborts the command.
// Ports:
//   i_wb_clk  clock, all logic on the rising edge
//   i_wb_rst  synchronous active-high reset
//   io_bus    master modport of wb_sdrc_master_if (cmd_*, wd_*, rd_*, done/err, wb_*)
module wb_sdrc_master
  import sdrc_wb_pkg::*;
#(
  parameter int unsigned APP_AW      = 26,
  parameter int unsigned DW          = 32,
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input logic                    i_wb_clk,
  input logic                    i_wb_rst,
  wb_sdrc_master_if.master       io_bus
);

  localparam int unsigned      TW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [APP_AW-1:0] ADDR_INC = APP_AW'(DW / 8);
  // Abort on the edge that would bring the stall count to TIMEOUT_CYC.
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT_CYC - 1);

  wbm_state_t        r_state, w_state_nxt;
  logic              r_we;
  logic [APP_AW-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [DW/8-1:0]   r_sel;
  logic [TW-1:0]     r_tmo;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [DW-1:0]     r_rd_data;
  logic              r_done;
  logic              r_err;

  logic w_cyc, w_stb, w_beat, w_last, w_timeout, w_accept, w_drain_beat;

  always_comb begin
    w_state_nxt  = r_state;
    w_cyc        = 1'b0;
    w_stb        = 1'b0;
    w_beat       = 1'b0;
    w_timeout    = 1'b0;
    w_accept     = 1'b0;
    w_drain_beat = 1'b0;
    w_last       = (r_cnt == r_len);
    unique case (r_state)
      IDLE: begin
        w_accept = io_bus.cmd_valid;
        if (w_accept) w_state_nxt = BUS;
      end
      BUS: begin
        w_cyc     = 1'b1;
        // Writes stall with stb low (cyc held) until a data beat is offered.
        w_stb     = r_we ? io_bus.wd_valid : 1'b1;
        w_beat    = w_stb && io_bus.wb_ack;
        w_timeout = w_stb && !io_bus.wb_ack && (r_tmo == TMO_LAST);
        if (w_beat && w_last) w_state_nxt = IDLE;
        else if (w_timeout)   w_state_nxt = r_we ? DRAIN : IDLE;
      end
      DRAIN: begin
        // r_cnt continues from the completed-beat count, so this discards exactly the rest.
        w_drain_beat = io_bus.wd_valid;
        if (w_drain_beat && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state    <= IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_tmo      <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      if (w_accept) begin
        r_we   <= io_bus.cmd_we;
        r_addr <= io_bus.cmd_addr;
        r_len  <= io_bus.cmd_len;
        r_sel  <= io_bus.cmd_sel;
        r_cnt  <= '0;
        r_tmo  <= '0;
      end
      if (w_beat) begin
        r_addr <= r_addr + ADDR_INC;
        r_cnt  <= r_cnt + 1'b1;
        r_tmo  <= '0;
        if (!r_we) begin
          r_rd_valid <= 1'b1;
          r_rd_data  <= io_bus.wb_dato;
          r_rd_last  <= w_last;
        end
        if (w_last) r_done <= 1'b1;
      end else if (w_stb) begin
        r_tmo <= r_tmo + 1'b1;
      end
      if (w_timeout) begin
        r_done <= 1'b1;
        r_err  <= 1'b1;
      end
      if (w_drain_beat) r_cnt <= r_cnt + 1'b1;
    end
  end

  // cmd_ready is masked during reset so every output reads 0 while wb_rst is held.
  assign io_bus.cmd_ready = (r_state == IDLE) && !i_wb_rst;
  assign io_bus.wd_ready  = (w_beat && r_we) || (r_state == DRAIN);
  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.rd_last   = r_rd_last;
  assign io_bus.done      = r_done;
  assign io_bus.err       = r_err;
  assign io_bus.wb_cyc    = w_cyc;
  assign io_bus.wb_stb    = w_stb;
  assign io_bus.wb_we     = w_cyc && r_we;
  assign io_bus.wb_sel    = w_cyc ? r_sel : '0;
  assign io_bus.wb_addr   = r_addr;
  assign io_bus.wb_dati   = (w_cyc && r_we) ? io_bus.wd_data : '0;
  assign io_bus.wb_cti    = !w_cyc         ? CTI_CLASSIC :
                            (r_len == '0)  ? CTI_CLASSIC :
                            w_last         ? CTI_EOB     : CTI_INCR;

endmodule

// File: tb/tb_wb_sdrc_master.sv
// Self-checking bench for wb_sdrc_master: directed command sequence, a Wishbone slave model that
// acks one cycle after stb, a write-data feeder, and scoreboard queues for bus beats, read
// responses and done/err pulses.
module tb_wb_sdrc_master;
  import sdrc_wb_pkg::*;

  localparam int unsigned APP_AW      = 26;
  localparam int unsigned DW          = 32;
  localparam int unsigned LEN_W       = 4;
  localparam int unsigned TIMEOUT_CYC = 8;

  typedef struct packed {
    logic [7:0]  gap;
    logic [31:0] data;
  } wd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_sdrc_master_if #(.APP_AW(APP_AW), .DW(DW), .LEN_W(LEN_W)) bus ();

  wb_sdrc_master #(
    .APP_AW     (APP_AW),
    .DW         (DW),
    .LEN_W      (LEN_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .i_wb_clk(clk),
    .i_wb_rst(rst),
    .io_bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_beats = 0;
  int n_gap = 0;
  int n_wd_taken = 0;
  logic ack_en = 1'b1;

  logic [65:0] exp_wb[$];   // {addr, cti, we, sel, data}
  logic [32:0] exp_rd[$];   // {last, data}
  logic        exp_done[$]; // expected err flag of each done pulse
  wd_t         wd_q[$];

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dato_fn(input logic [25:0] a);
    return 32'hC0DE_0000 ^ {6'd0, a};
  endfunction

  function automatic logic [65:0] beat(input logic [25:0] a, input logic [2:0] cti,
                                       input logic we, input logic [3:0] sel,
                                       input logic [31:0] d);
    return {a, cti, we, sel, d};
  endfunction

  function automatic logic [2:0] cti_of(input int i, input int len);
    if (len == 0) return 3'b000;
    return (i == len) ? 3'b111 : 3'b010;
  endfunction

  // Slave model, write-data feeder and output monitor in one process to keep ordering fixed.
  initial begin
    logic seen, take;
    logic [7:0] wd_gap;
    seen = 1'b0;
    wd_gap = '0;
    bus.wb_ack = 1'b0;
    bus.wb_dato = '0;
    bus.wd_valid = 1'b0;
    bus.wd_data = '0;
    forever begin
      @(negedge clk);
      if (bus.wb_ack) bus.wb_ack = 1'b0;
      else bus.wb_ack = ack_en && bus.wb_stb && seen;
      seen = bus.wb_stb && !bus.wb_ack;
      bus.wb_dato = dato_fn(bus.wb_addr);
      #1;
      if (bus.wb_cyc && !bus.wb_stb) n_gap++;
      if (bus.wb_stb && bus.wb_ack) begin
        n_beats++;
        chk("wb_beat_expected", 96'(exp_wb.size() != 0), 96'd1);
        if (exp_wb.size() != 0)
          chk("wb_beat", {bus.wb_addr, bus.wb_cti, bus.wb_we, bus.wb_sel,
                          (bus.wb_we ? bus.wb_dati : 32'h0)}, exp_wb.pop_front());
      end
      take = bus.wd_valid && bus.wd_ready;
      if (bus.rd_valid) begin
        chk("rd_expected", 96'(exp_rd.size() != 0), 96'd1);
        if (exp_rd.size() != 0) chk("rd_beat", {bus.rd_last, bus.rd_data}, exp_rd.pop_front());
      end
      if (bus.done) begin
        chk("done_expected", 96'(exp_done.size() != 0), 96'd1);
        if (exp_done.size() != 0) chk("done_err", bus.err, exp_done.pop_front());
      end
      if (bus.err) chk("err_with_done", bus.done, 1);
      @(posedge clk);
      #1;
      if (take && wd_q.size() != 0) begin
        void'(wd_q.pop_front());
        n_wd_taken++;
        wd_gap = (wd_q.size() != 0) ? wd_q[0].gap : 8'd0;
      end
      if (wd_q.size() != 0 && wd_gap == 0) begin
        bus.wd_valid = 1'b1;
        bus.wd_data  = wd_q[0].data;
      end else begin
        bus.wd_valid = 1'b0;
        if (wd_gap != 0) wd_gap--;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_read(input logic [25:0] addr, input int len, input logic [3:0] sel);
    logic [25:0] a;
    a = addr;
    for (int i = 0; i <= len; i++) begin
      exp_wb.push_back(beat(a, cti_of(i, len), 1'b0, sel, 32'h0));
      exp_rd.push_back({(i == len), dato_fn(a)});
      a = a + 26'd4;
    end
    exp_done.push_back(1'b0);
  endtask

  task automatic issue(input logic we, input logic [25:0] addr, input logic [3:0] len,
                       input logic [3:0] sel, output int lows, output logic done_at_acc);
    logic acc;
    acc = 1'b0;
    lows = 0;
    done_at_acc = 1'b0;
    bus.cmd_we = we;
    bus.cmd_addr = addr;
    bus.cmd_len = len;
    bus.cmd_sel = sel;
    bus.cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      if (!bus.wb_cyc) lows++;
      if (bus.cmd_ready) begin
        acc = 1'b1;
        done_at_acc = bus.done;
      end
      step();
    end
    chk("cmd_accepted", acc, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_done.size() != 0; i++) step();
    chk("done_seen", 96'(exp_done.size() == 0), 96'd1);
    step();
    chk("rd_all_seen", 96'(exp_rd.size() + exp_wb.size()), 96'd0);
  endtask

  task automatic count_cyc(output int n);
    n = 0;
    for (int i = 0; i < 50 && bus.wb_cyc; i++) begin
      n++;
      step();
    end
  endtask

  initial begin
    int lows, n, b0, t0, g0;
    logic dacc;
    logic [25:0] a;
    bus.cmd_valid = 1'b0;
    bus.cmd_we = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.cmd_sel = '0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    chk("reset_outputs", {bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.done, bus.err,
                          bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_sel, bus.wb_cti}, 0);
    chk("reset_addr", bus.wb_addr, 0);
    rst = 1'b0;
    step();
    chk("idle_ready", bus.cmd_ready, 1);

    // Single read
    b0 = n_beats;
    push_read(26'h100, 0, 4'hF);
    issue(1'b0, 26'h100, 4'd0, 4'hF, lows, dacc);
    bus.cmd_valid = 1'b0;
    wait_done();
    chk("single_read_beats", n_beats - b0, 1);

    // Write burst with a one-cycle data gap before beat 2
    wd_q.push_back('{gap: 8'd0, data: 32'hA0});
    wd_q.push_back('{gap: 8'd0, data: 32'hA1});
    wd_q.push_back('{gap: 8'd1, data: 32'hA2});
    wd_q.push_back('{gap: 8'd0, data: 32'hA3});
    repeat (2) step();
    for (int i = 0; i < 4; i++)
      exp_wb.push_back(beat(26'h200 + 26'(4 * i), cti_of(i, 3), 1'b1, 4'b0110, 32'hA0 + 32'(i)));
    exp_done.push_back(1'b0);
    g0 = n_gap;
    t0 = n_wd_taken;
    b0 = n_beats;
    issue(1'b1, 26'h200, 4'd3, 4'b0110, lows, dacc);
    bus.cmd_valid = 1'b0;
    wait_done();
    chk("write_gap_cycles", n_gap - g0, 1);
    chk("write_wd_taken", n_wd_taken - t0, 4);
    chk("write_beats", n_beats - b0, 4);

    // Read burst wrapping the address space
    push_read(26'h3FFFFF8, 3, 4'hF);
    issue(1'b0, 26'h3FFFFF8, 4'd3, 4'hF, lows, dacc);
    bus.cmd_valid = 1'b0;
    wait_done();

    // Read timeout
    ack_en = 1'b0;
    exp_done.push_back(1'b1);
    issue(1'b0, 26'h500, 4'd0, 4'hF, lows, dacc);
    bus.cmd_valid = 1'b0;
    count_cyc(n);
    chk("rd_timeout_cycles", n, TIMEOUT_CYC);
    chk("rd_timeout_flags", {bus.done, bus.err, bus.wb_stb}, 3'b110);
    ack_en = 1'b1;
    wait_done();

    // Write timeout with drain of the unsent beats
    wd_q.push_back('{gap: 8'd0, data: 32'hB0});
    wd_q.push_back('{gap: 8'd0, data: 32'hB1});
    repeat (2) step();
    ack_en = 1'b0;
    exp_done.push_back(1'b1);
    t0 = n_wd_taken;
    issue(1'b1, 26'h600, 4'd1, 4'hF, lows, dacc);
    bus.cmd_valid = 1'b0;
    count_cyc(n);
    chk("wr_timeout_cycles", n, TIMEOUT_CYC);
    chk("wr_timeout_flags", {bus.done, bus.err, bus.wd_ready}, 3'b111);
    for (int i = 0; i < 20 && !bus.cmd_ready; i++) step();
    chk("drain_to_idle", bus.cmd_ready, 1);
    chk("drain_wd_count", n_wd_taken - t0, 2);
    chk("drain_queue_empty", 96'(wd_q.size()), 96'd0);
    ack_en = 1'b1;
    wait_done();

    // Reset during beat 2 of a 4-beat read
    b0 = n_beats;
    push_read(26'h1000, 3, 4'hF);
    issue(1'b0, 26'h1000, 4'd3, 4'hF, lows, dacc);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 100 && n_beats < b0 + 2; i++) step();
    chk("pre_reset_beats", n_beats - b0, 2);
    rst = 1'b1;
    step();
    chk("midburst_reset", {bus.cmd_ready, bus.wd_ready, bus.rd_valid, bus.done, bus.err,
                           bus.wb_cyc, bus.wb_stb, bus.wb_we, bus.wb_cti}, 0);
    exp_wb.delete();
    exp_rd.delete();
    exp_done.delete();
    rst = 1'b0;
    step();
    chk("post_reset_ready", bus.cmd_ready, 1);
    push_read(26'h40, 0, 4'h3);
    issue(1'b0, 26'h40, 4'd0, 4'h3, lows, dacc);
    bus.cmd_valid = 1'b0;
    wait_done();

    // Back-to-back commands with cmd_valid held
    push_read(26'h300, 0, 4'hF);
    push_read(26'h400, 1, 4'hF);
    issue(1'b0, 26'h300, 4'd0, 4'hF, lows, dacc);
    issue(1'b0, 26'h400, 4'd1, 4'hF, lows, dacc);
    chk("b2b_cyc_low_cycles", lows, 1);
    chk("b2b_accept_in_done", dacc, 1);
    chk("b2b_cyc_restart", bus.wb_cyc, 1);
    bus.cmd_valid = 1'b0;
    wait_done();

    repeat (3) step();
    chk("scoreboard_empty", 96'(exp_wb.size() + exp_rd.size() + exp_done.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
